vc_dd_sel_arbiter: RTL and testbench

- Two-requester, domain-aware, round-robin arbiter that sits directly upstream of the vc_Mux2_dd / vc_Mux2_dd_Ctrl select logic.
- Owns the mux `sel` and `out_domain`, and holds a grant for a whole multi-beat transaction.
- Returns val/rdy backpressure to each requester.
- Releases a stalled grant via an idle-timeout counter so one domain cannot starve the other.

---
 rtl/vc_dd_pkg.sv | 17 +
 rtl/vc_dd_arb_timer.sv | 31 +++
 rtl/vc_dd_sel_arbiter.sv | 128 ++++++++++++
 tb/tb_vc_dd_sel_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_dd_pkg.sv
// Shared types and constants for the vc_dd select arbiter and mux stage.
package vc_dd_pkg;

    localparam int VC_DD_DOMAIN_W = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    localparam logic [VC_DD_DOMAIN_W-1:0] VC_DD_DOM0 = 2'd0;
    localparam logic [VC_DD_DOMAIN_W-1:0] VC_DD_DOM1 = 2'd1;
    localparam logic [VC_DD_DOMAIN_W-1:0] VC_DD_DOM2 = 2'd2;
    localparam logic [VC_DD_DOMAIN_W-1:0] VC_DD_DOM3 = 2'd3;

endpackage

// File: rtl/vc_dd_arb_timer.sv
// Saturating idle-timeout counter; expire flags the last allowed idle cycle.
module vc_dd_arb_timer
    import vc_dd_pkg::*;
#(
    parameter int p_timeout = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int W = $clog2(p_timeout + 1);
    localparam logic [W-1:0] LIM = W'(p_timeout - 1);

    logic [W-1:0] tcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (clr) begin
            tcnt <= '0;
        end else if (inc && tcnt != '1) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign expire = inc & (tcnt == LIM);

endmodule

// File: rtl/vc_dd_sel_arbiter.sv
// Two-requester domain-aware round-robin arbiter driving the dd mux select.
// Define VC_DD_ARB_DOMAIN_CHECK_EN to add the sticky err_domain output.
module vc_dd_sel_arbiter
    import vc_dd_pkg::*;
#(
    parameter int p_timeout = 8,
    parameter int p_dwidth  = VC_DD_DOMAIN_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_val,
    input  logic                req0_last,
    input  logic [p_dwidth-1:0] req0_domain,
    output logic                req0_rdy,
    input  logic                req1_val,
    input  logic                req1_last,
    input  logic [p_dwidth-1:0] req1_domain,
    output logic                req1_rdy,
    output logic                out_val,
    input  logic                out_rdy,
    output logic                sel,
    output logic [p_dwidth-1:0] out_domain,
`ifdef VC_DD_ARB_DOMAIN_CHECK_EN
    output logic                err_domain,
`endif
    output logic                busy
);

    arb_state_t state;
    logic       last_gnt;
    logic       in_gnt;
    logic       g1;
    logic       cur_val;
    logic       cur_last;
    logic       oth_val;
    logic       dom_err;
    logic       pass;
    logic       fire;
    logic       expire;
    logic       gnt_go;
    logic       gnt_id;
    logic       drop;

    always_comb begin
        in_gnt   = (state == ARB_GNT0) || (state == ARB_GNT1);
        g1       = (state == ARB_GNT1);
        cur_val  = g1 ? req1_val  : req0_val;
        cur_last = g1 ? req1_last : req0_last;
        oth_val  = g1 ? req0_val  : req1_val;
    end

`ifdef VC_DD_ARB_DOMAIN_CHECK_EN
    assign dom_err = in_gnt & cur_val
                   & ((g1 ? req1_domain : req0_domain) != out_domain);
`else
    assign dom_err = 1'b0;
`endif

    assign pass     = in_gnt & ~dom_err;
    assign out_val  = pass & cur_val;
    assign req0_rdy = pass & ~g1 & out_rdy;
    assign req1_rdy = pass &  g1 & out_rdy;
    assign fire     = out_val & out_rdy;
    assign busy     = in_gnt;

    vc_dd_arb_timer #(
        .p_timeout (p_timeout)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (~in_gnt | cur_val),
        .inc    (in_gnt & ~cur_val),
        .expire (expire)
    );

    // Ties go to whoever did not hold the last grant.
    always_comb begin
        gnt_go = 1'b0;
        gnt_id = 1'b0;
        drop   = 1'b0;
        unique case (1'b1)
            !in_gnt: begin
                gnt_go = req0_val | req1_val;
                gnt_id = req1_val & (~req0_val | ~last_gnt);
            end
            dom_err: begin
                drop = 1'b1;
            end
            (fire & cur_last): begin
                gnt_go = oth_val;
                gnt_id = ~g1;
                drop   = ~oth_val;
            end
            expire: begin
                drop = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            sel        <= 1'b0;
            out_domain <= '0;
            last_gnt   <= 1'b1;
        end else if (gnt_go) begin
            state      <= gnt_id ? ARB_GNT1 : ARB_GNT0;
            sel        <= gnt_id;
            out_domain <= gnt_id ? req1_domain : req0_domain;
            last_gnt   <= gnt_id;
        end else if (drop) begin
            state      <= ARB_IDLE;
        end
    end

`ifdef VC_DD_ARB_DOMAIN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_domain <= 1'b0;
        end else if (dom_err) begin
            err_domain <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vc_dd_sel_arbiter.sv
// Directed and random checks of vc_dd_sel_arbiter against a behavioural model.
module tb_vc_dd_sel_arbiter;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_val, req0_last, req0_rdy;
    logic       req1_val, req1_last, req1_rdy;
    logic [1:0] req0_domain, req1_domain, out_domain;
    logic       out_val, out_rdy, sel, busy;
`ifdef VC_DD_ARB_DOMAIN_CHECK_EN
    logic       err_domain;
`endif

    int checks = 0;
    int errors = 0;

    // model: owner -1 = nobody holds the grant
    int         m_owner;
    int         m_last;
    int         m_idle;
    int         m_sel;
    logic [1:0] m_dom;
    logic       m_err;

    always #5 clk = ~clk;

    vc_dd_sel_arbiter #(
        .p_timeout (TMO),
        .p_dwidth  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_val    (req0_val),
        .req0_last   (req0_last),
        .req0_domain (req0_domain),
        .req0_rdy    (req0_rdy),
        .req1_val    (req1_val),
        .req1_last   (req1_last),
        .req1_domain (req1_domain),
        .req1_rdy    (req1_rdy),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .sel         (sel),
        .out_domain  (out_domain),
`ifdef VC_DD_ARB_DOMAIN_CHECK_EN
        .err_domain  (err_domain),
`endif
        .busy        (busy)
    );

    function automatic logic vof(int n);
        return (n == 0) ? req0_val : req1_val;
    endfunction

    function automatic logic lof(int n);
        return (n == 0) ? req0_last : req1_last;
    endfunction

    function automatic logic [1:0] dof(int n);
        return (n == 0) ? req0_domain : req1_domain;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_idle  = 0;
        m_sel   = 0;
        m_dom   = 2'd0;
        m_err   = 1'b0;
    endtask

    task automatic grant(input int n);
        m_owner = n;
        m_last  = n;
        m_sel   = n;
        m_dom   = dof(n);
        m_idle  = 0;
    endtask

    function automatic logic mism();
        logic r;
        r = 1'b0;
`ifdef VC_DD_ARB_DOMAIN_CHECK_EN
        r = (m_owner >= 0) && vof(m_owner) && (dof(m_owner) != m_dom);
`endif
        return r;
    endfunction

    task automatic model_update();
        int o;
        o = m_owner;
        if (o < 0) begin
            if (req0_val && req1_val) grant(1 - m_last);
            else if (req0_val)        grant(0);
            else if (req1_val)        grant(1);
        end else if (mism()) begin
            m_err   = 1'b1;
            m_owner = -1;
        end else if (vof(o) && out_rdy && lof(o)) begin
            if (vof(1 - o)) grant(1 - o);
            else            m_owner = -1;
        end else if (!vof(o)) begin
            m_idle++;
            if (m_idle == TMO) m_owner = -1;
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic check_outputs();
        logic ok;
        ok = (m_owner >= 0) && !mism();
        chk("busy",     {7'd0, busy},     {7'd0, m_owner >= 0});
        chk("sel",      {7'd0, sel},      8'(m_sel));
        chk("domain",   {6'd0, out_domain}, {6'd0, m_dom});
        chk("out_val",  {7'd0, out_val},  {7'd0, ok && vof(m_owner)});
        chk("req0_rdy", {7'd0, req0_rdy}, {7'd0, ok && m_owner == 0 && out_rdy});
        chk("req1_rdy", {7'd0, req1_rdy}, {7'd0, ok && m_owner == 1 && out_rdy});
`ifdef VC_DD_ARB_DOMAIN_CHECK_EN
        chk("err_domain", {7'd0, err_domain}, {7'd0, m_err});
`endif
    endtask

    // inputs are changed by the caller at posedge+1; check at negedge+1
    task automatic step();
        @(negedge clk);
        #1;
        check_outputs();
        @(posedge clk);
        if (reset) model_update();
        #1;
    endtask

    task automatic set_in(input logic v0, input logic l0,
                          input logic v1, input logic l1, input logic rdy);
        req0_val  = v0;
        req0_last = l0;
        req1_val  = v1;
        req1_last = l1;
        out_rdy   = rdy;
    endtask

    initial begin
        int p0, p1;
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0);
        req0_domain = 2'b00;
        req1_domain = 2'b00;
        model_reset();
        step();
        step();
        reset = 1'b1;

        // single 3-beat burst from requester 0
        req0_domain = 2'b01;
        set_in(1, 0, 0, 0, 1);
        step();
        step();
        step();
        req0_last = 1'b1;
        step();
        set_in(0, 0, 0, 0, 1);
        step();
        step();

        // both always valid with 1-beat transactions
        set_in(1, 1, 1, 1, 1);
        req1_domain = 2'b10;
        repeat (8) step();
        set_in(0, 0, 0, 0, 1);
        step();
        step();

        // requester 1 goes idle while holding the grant
        set_in(0, 0, 1, 0, 1);
        step();
        step();
        set_in(1, 0, 0, 0, 1);
        repeat (11) step();

        // backpressure is not idleness
        set_in(1, 1, 0, 0, 0);
        repeat (20) step();
        out_rdy = 1'b1;
        step();
        set_in(0, 0, 0, 0, 1);
        step();

        // asynchronous reset in the middle of a GNT1 burst
        set_in(0, 0, 1, 0, 1);
        step();
        step();
        step();
        reset = 1'b0;
        #1;
        chk("arst_busy",  {7'd0, busy},     8'd0);
        chk("arst_sel",   {7'd0, sel},      8'd0);
        chk("arst_dom",   {6'd0, out_domain}, 8'd0);
        chk("arst_val",   {7'd0, out_val},  8'd0);
        chk("arst_rdy1",  {7'd0, req1_rdy}, 8'd0);
        model_reset();
        set_in(1, 0, 1, 0, 1);
        step();
        reset = 1'b1;
        step();
        step();
        chk("tie_after_reset", {7'd0, sel}, 8'd0);
        set_in(0, 0, 0, 0, 1);
        step();
        step();

`ifdef VC_DD_ARB_DOMAIN_CHECK_EN
        req0_domain = 2'b01;
        set_in(1, 0, 0, 0, 1);
        step();
        step();
        req0_domain = 2'b10;
        step();
        set_in(0, 0, 0, 0, 1);
        step();
        step();
`endif

        // random traffic with slowly changing valid densities
        p0 = 5;
        p1 = 5;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                p0 = $urandom_range(1, 9);
                p1 = $urandom_range(0, 9);
            end
            req0_val  = $urandom_range(0, 9) < p0;
            req1_val  = $urandom_range(0, 9) < p1;
            req0_last = $urandom_range(0, 3) == 0;
            req1_last = $urandom_range(0, 3) == 0;
            out_rdy   = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 15) == 0) req0_domain = 2'($urandom);
            if ($urandom_range(0, 15) == 0) req1_domain = 2'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
